// File: rtl/eth_tx_sequencer_pkg.sv
// Shared definitions for the Ethernet TX/RX sequencers and the APB front-end:
// the sequencer state encoding, default frame sizing and the length check.
package eth_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_PAD,
        ST_IFG
    } tx_state_t;

    localparam int LEN_W              = 16;
    localparam int MTU_DEFAULT        = 1536;
    localparam int MIN_FRAME_DEFAULT  = 60;
    localparam int IFG_CYCLES_DEFAULT = 12;

    // A frame length is usable when it is non-zero and fits in the buffer.
    function automatic logic len_valid(input logic [LEN_W-1:0] len,
                                       input logic [LEN_W-1:0] max_len);
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/eth_ifg_timer.sv
// Loadable down-counter: after a load of N it counts N..0 and raises done
// combinationally during the cycle in which the count reaches zero.
module eth_ifg_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             active;

    // Count down from the loaded value and stop once zero has been reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/eth_tx_sequencer.sv
// Streams one TX frame from the frame buffer into the MAC byte stream,
// zero-pads runts, holds the inter-frame gap and raises a sticky done irq.
module eth_tx_sequencer
    import eth_tx_sequencer_pkg::*;
#(
    parameter int MTU        = MTU_DEFAULT,
    parameter int ADDR_W     = 11,
    parameter int MIN_FRAME  = MIN_FRAME_DEFAULT,
    parameter int IFG_CYCLES = IFG_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       tx_len,
    output logic              busy,
    output logic              err_len,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              irq_done,
    input  logic              irq_ack,
    output logic [15:0]       frames_sent
);

    localparam int                CNT_W        = 16;
    localparam logic [LEN_W-1:0]  MTU_L        = LEN_W'(MTU);
    localparam logic [LEN_W-1:0]  MIN_L        = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0]  PAD_LAST_IDX = LEN_W'(MIN_FRAME - 1);
    // The timer counts N-1..0, so done lands on the final gap cycle.
    localparam logic [CNT_W-1:0]  IFG_LOAD     = CNT_W'(IFG_CYCLES - 1);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W-1:0] idx_q, idx_nxt;
    logic             err_nxt;
    logic             ifg_load;
    logic             ifg_done;
    logic             irq_set;
    logic             last_data;
    logic             runt;

    assign last_data = (idx_q == (len_q - 16'd1));
    assign runt      = (len_q < MIN_L);
    assign irq_set   = (state == ST_IFG) && ifg_done;

    eth_ifg_timer #(
        .CNT_W (CNT_W)
    ) u_ifg_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ifg_load),
        .load_val (IFG_LOAD),
        .done     (ifg_done)
    );

    // State, frame length, byte index and the registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            err_len <= 1'b0;
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            idx_q   <= idx_nxt;
            err_len <= err_nxt;
        end
    end

    // Next-state logic and stream/buffer outputs for the current state.
    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        idx_nxt   = idx_q;
        err_nxt   = 1'b0;
        ifg_load  = 1'b0;
        busy      = (state != ST_IDLE);
        buf_addr  = '0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !irq_done) begin
                    if (len_valid(tx_len, MTU_L)) begin
                        len_nxt   = tx_len;
                        idx_nxt   = '0;
                        state_nxt = ST_FETCH;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                buf_addr  = '0;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                tx_valid = 1'b1;
                tx_data  = buf_rdata;
                tx_last  = last_data && !runt;
                // Holding the address while stalled keeps buf_rdata stable.
                buf_addr = tx_ready ? ADDR_W'(idx_q + 16'd1) : ADDR_W'(idx_q);
                if (tx_ready) begin
                    if (last_data) begin
                        if (runt) begin
                            idx_nxt   = idx_q + 16'd1;
                            state_nxt = ST_PAD;
                        end else begin
                            ifg_load  = 1'b1;
                            state_nxt = ST_IFG;
                        end
                    end else begin
                        idx_nxt = idx_q + 16'd1;
                    end
                end
            end
            ST_PAD: begin
                tx_valid = 1'b1;
                tx_last  = (idx_q == PAD_LAST_IDX);
                if (tx_ready) begin
                    if (idx_q == PAD_LAST_IDX) begin
                        ifg_load  = 1'b1;
                        state_nxt = ST_IFG;
                    end else begin
                        idx_nxt = idx_q + 16'd1;
                    end
                end
            end
            ST_IFG: begin
                if (ifg_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky completion irq (a set beats a simultaneous ack) and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_done    <= 1'b0;
            frames_sent <= '0;
        end else begin
            if (irq_set) begin
                irq_done    <= 1'b1;
                frames_sent <= frames_sent + 16'd1;
            end else if (irq_ack) begin
                irq_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Scoreboard bench for eth_tx_sequencer: expected stream bytes are queued
// when a frame is launched and popped by a monitor on every transfer.
module tb_eth_tx_sequencer;

    localparam int ADDR_W = 11;
    localparam int MINF   = 60;
    localparam int IFG    = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       tx_len = '0;
    logic              busy;
    logic              err_len;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_rdata = '0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              tx_last;
    logic              irq_done;
    logic              irq_ack = 1'b0;
    logic [15:0]       frames_sent;

    logic [7:0] mem [0:2047];
    logic [8:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = -1;
    int bytes_seen = 0;
    int exp_frames = 0;
    bit stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    eth_tx_sequencer #(
        .MTU        (1536),
        .ADDR_W     (ADDR_W),
        .MIN_FRAME  (MINF),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tx_len      (tx_len),
        .busy        (busy),
        .err_len     (err_len),
        .buf_addr    (buf_addr),
        .buf_rdata   (buf_rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .irq_done    (irq_done),
        .irq_ack     (irq_ack),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM model with one cycle of read latency.
    always @(posedge clk) buf_rdata <= mem[buf_addr];

    // Stream monitor: pops the scoreboard on each transfer, checks stall hold.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%02h last=%b, required valid=1 data=%02h last=%b",
                             tx_valid, tx_data, tx_last, prev_data, prev_last);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                logic [8:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: data=%02h last=%b, required no transfer", tx_data, tx_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_last, tx_data} !== e) begin
                        errors++;
                        $display("FAIL stream_byte: last=%b data=%02h, required last=%b data=%02h",
                                 tx_last, tx_data, e[8], e[7:0]);
                    end
                end
                bytes_seen++;
                if (tx_last === 1'b1) last_cyc = cyc;
            end
            stall_prev = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic push_frame(input int len);
        int n;
        n = (len < MINF) ? MINF : len;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), (i < len) ? mem[i] : 8'h00});
        end
    endtask

    task automatic do_start(input logic [15:0] len, output int s);
        @(posedge clk); #1;
        start  = 1'b1;
        tx_len = len;
        s      = cyc;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic run_until_irq(input int budget, input bit stall_pat,
                                 input bit ack_at_set, output int irq_cyc);
        int k;
        bit got;
        k = 0;
        got = 1'b0;
        irq_cyc = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            tx_ready = stall_pat ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            k++;
            irq_ack = ack_at_set && (last_cyc >= 0) && (cyc == last_cyc + IFG);
            @(negedge clk);
            if (irq_done === 1'b1) begin
                got = 1'b1;
                irq_cyc = cyc;
            end
        end
        tx_ready = 1'b1;
        irq_ack  = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL irq_timeout: irq_done=%b after %0d cycles, required 1", irq_done, budget);
        end
    endtask

    task automatic ack_irq();
        @(posedge clk); #1;
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (irq_done !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq_done=%b, required 0", irq_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, err_len, tx_valid, tx_last, irq_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/err/valid/last/irq=%b, required 00000",
                     {busy, err_len, tx_valid, tx_last, irq_done});
        end
        checks++;
        if (buf_addr !== '0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: buf_addr=%0h tx_data=%02h, required 0 and 00", buf_addr, tx_data);
        end
        checks++;
        if (frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset_frames: frames_sent=%0d, required 0", frames_sent);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int s, ic;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        push_frame(64);
        last_cyc = -1;
        do_start(16'd64, s);
        @(negedge clk);
        checks++;
        if (cyc != s + 1 || tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_fetch: valid=%b busy=%b, required valid=0 busy=1", tx_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_valid: valid=%b two cycles after start, required 1", tx_valid);
        end
        run_until_irq(300, 1'b0, 1'b0, ic);
        exp_frames++;
        checks++;
        if (ic - last_cyc != IFG + 1) begin
            errors++;
            $display("FAIL basic_ifg: idle cycles before irq=%0d, required %0d", ic - last_cyc - 1, IFG);
        end
        checks++;
        if (frames_sent !== 16'(exp_frames) || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: frames_sent=%0d busy=%b, required %0d busy=0", frames_sent, busy, exp_frames);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: %0d bytes not seen, required 0", exp_q.size());
        end
        ack_irq();
    endtask

    task automatic test_pad();
        int s, ic;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i + 1);
        push_frame(10);
        last_cyc = -1;
        do_start(16'd10, s);
        run_until_irq(300, 1'b0, 1'b0, ic);
        exp_frames++;
        checks++;
        if (exp_q.size() != 0 || frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL pad_done: left=%0d frames=%0d, required left=0 frames=%0d",
                     exp_q.size(), frames_sent, exp_frames);
        end
        checks++;
        if (ic - last_cyc != IFG + 1) begin
            errors++;
            $display("FAIL pad_ifg: idle cycles=%0d, required %0d", ic - last_cyc - 1, IFG);
        end
        ack_irq();
    endtask

    task automatic test_stall();
        int s, ic;
        for (int i = 0; i < 2048; i++) mem[i] = 8'hA5 ^ 8'(i);
        push_frame(64);
        last_cyc = -1;
        do_start(16'd64, s);
        run_until_irq(600, 1'b1, 1'b0, ic);
        exp_frames++;
        checks++;
        if (exp_q.size() != 0 || frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL stall_done: left=%0d frames=%0d, required left=0 frames=%0d",
                     exp_q.size(), frames_sent, exp_frames);
        end
        ack_irq();
    endtask

    task automatic test_len_err();
        int s;
        logic [15:0] bad [2];
        bad[0] = 16'd0;
        bad[1] = 16'd1537;
        for (int b = 0; b < 2; b++) begin
            do_start(bad[b], s);
            @(negedge clk);
            checks++;
            if (err_len !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL len_err_pulse len=%0d: err=%b busy=%b valid=%b, required 1 0 0",
                         bad[b], err_len, busy, tx_valid);
            end
            @(negedge clk);
            checks++;
            if (err_len !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL len_err_end len=%0d: err=%b busy=%b valid=%b, required 0 0 0",
                         bad[b], err_len, busy, tx_valid);
            end
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL len_err_frames: frames_sent=%0d, required %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_mtu();
        int s, ic;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7);
        push_frame(1536);
        last_cyc = -1;
        do_start(16'd1536, s);
        @(negedge clk);
        checks++;
        if (err_len !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mtu_accept: err=%b busy=%b, required err=0 busy=1", err_len, busy);
        end
        run_until_irq(2000, 1'b0, 1'b0, ic);
        exp_frames++;
        checks++;
        if (exp_q.size() != 0 || frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL mtu_done: left=%0d frames=%0d, required left=0 frames=%0d",
                     exp_q.size(), frames_sent, exp_frames);
        end
        ack_irq();
    endtask

    task automatic test_ignore();
        int s, s2, ic;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(255 - i);
        push_frame(64);
        last_cyc = -1;
        do_start(16'd64, s);
        repeat (10) @(posedge clk);
        do_start(16'd5, s2);
        @(negedge clk);
        checks++;
        if (err_len !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy: err=%b busy=%b, required err=0 busy=1", err_len, busy);
        end
        run_until_irq(300, 1'b0, 1'b1, ic);
        exp_frames++;
        @(negedge clk);
        checks++;
        if (irq_done !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_ack: irq_done=%b, required 1", irq_done);
        end
        checks++;
        if (frames_sent !== 16'(exp_frames) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_frames: frames=%0d left=%0d, required %0d and 0",
                     frames_sent, exp_q.size(), exp_frames);
        end
        do_start(16'd60, s);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || err_len !== 1'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignore_irq: busy=%b err=%b valid=%b, required 0 0 0", busy, err_len, tx_valid);
            end
        end
        ack_irq();
    endtask

    task automatic test_rst_mid();
        int s, ic, base;
        bit reached;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h3C;
        push_frame(100);
        last_cyc = -1;
        base = bytes_seen;
        reached = 1'b0;
        do_start(16'd100, s);
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (bytes_seen - base >= 20) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_mid_wait: bytes=%0d, required 20", bytes_seen - base);
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        checks++;
        if ({busy, err_len, tx_valid, tx_last, irq_done} !== 5'b0 || buf_addr !== '0 ||
            tx_data !== 8'h00 || frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ctrl=%b addr=%0h data=%02h frames=%0d, required all 0",
                     {busy, err_len, tx_valid, tx_last, irq_done}, buf_addr, tx_data, frames_sent);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_frame(60);
        last_cyc = -1;
        do_start(16'd60, s);
        run_until_irq(300, 1'b0, 1'b0, ic);
        exp_frames++;
        checks++;
        if (frames_sent !== 16'(exp_frames) || exp_q.size() != 0 || ic - last_cyc != IFG + 1) begin
            errors++;
            $display("FAIL rst_mid_recover: frames=%0d left=%0d gap=%0d, required %0d 0 %0d",
                     frames_sent, exp_q.size(), ic - last_cyc - 1, exp_frames, IFG);
        end
        ack_irq();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_stall();
        test_len_err();
        test_mtu();
        test_ignore();
        test_rst_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_sequencer.md
Name: eth_tx_sequencer

Overview:
- Controller that sequences one Ethernet TX frame out of the byte-wide TX frame buffer (single-port BRAM, 1-cycle read latency) into a MAC byte stream with valid/ready handshake.
- Sits between the APB register front-end (which fills the buffer, writes the length and issues start) and the MAC/PHY transmit path.
- Validates length, pads runt frames to the minimum size, enforces the inter-frame gap, and raises a level completion interrupt that needs an explicit ack.

Parameters:
- MTU, 1536, frame buffer depth in bytes; largest legal tx_len.
- ADDR_W, 11, buffer address width; must satisfy 2^ADDR_W >= MTU.
- MIN_FRAME, 60, minimum bytes per frame on the stream, excluding FCS; short frames are zero-padded up to this size.
- IFG_CYCLES, 12, idle clk cycles after the last byte before completion.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send a frame.
- tx_len  in  16  frame length in bytes; sampled on an accepted start.
- busy  out  1  high from an accepted start through the end of IFG.
- err_len  out  1  one-cycle pulse when a start is rejected.
- buf_addr  out  ADDR_W  read address to the TX buffer.
- buf_rdata  in  8  buffer data, valid 1 cycle after buf_addr.
- tx_data  out  8  stream byte.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  MAC accepts the byte when tx_valid && tx_ready.
- tx_last  out  1  marks the final byte of the frame, including padding.
- irq_done  out  1  level completion interrupt.
- irq_ack  in  1  clears irq_done.
- frames_sent  out  16  count of completed frames; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async, rst=1): state IDLE. busy=0, err_len=0, buf_addr=0, tx_valid=0, tx_last=0, tx_data=0, irq_done=0, frames_sent=0.
- Reset asserted mid-frame aborts the frame immediately. No tx_last is produced and no irq is raised.
- States: IDLE, FETCH, STREAM, PAD, IFG.
- IDLE, start accepted (start=1, irq_done=0):
  - If tx_len==0 or tx_len>MTU: err_len=1 for the next cycle, stay IDLE, busy stays 0.
  - Otherwise latch len=tx_len, set idx=0, go to FETCH, busy=1.
- start is ignored when busy=1 or irq_done=1. No error is flagged in those cases.
- FETCH (1 cycle): buf_addr=0, tx_valid=0, then go to STREAM.
  - First tx_valid therefore appears 2 cycles after the start cycle.
- STREAM:
  - tx_valid=1, tx_data=buf_rdata (i.e. m[idx]).
  - buf_addr=idx+1 in a cycle where the transfer fires, else idx. Holding the address during a stall keeps buf_rdata stable.
  - tx_last=1 when idx==len-1 and len>=MIN_FRAME.
  - On the transfer of byte idx==len-1: go to PAD if len<MIN_FRAME, else go to IFG.
- PAD: tx_valid=1, tx_data=0x00. Keep counting idx up to MIN_FRAME-1; tx_last=1 at idx==MIN_FRAME-1. Go to IFG on that transfer.
- tx_valid, once high, must not drop and tx_data must not change until the byte transfers.
- IFG: tx_valid=0 for exactly IFG_CYCLES cycles. On the last IFG cycle:
  - set irq_done=1;
  - increment frames_sent (mod 2^16);
  - go to IDLE; busy=0 from the next cycle.
- irq_done: set as above; cleared the cycle after irq_ack=1 is sampled. If the set and the ack happen in the same cycle, the set wins.
- len==MTU is legal. idx never exceeds max(len, MIN_FRAME)-1.
- All length and index arithmetic is 16-bit unsigned.

Decomposition:
- Shared package: state enum, MTU/MIN_FRAME defaults, frame-length check constants. These are reused by the APB front-end and the future RX sequencer.
- One natural sub-module, eth_ifg_timer: a loadable down-counter with a done pulse. It is reused for RX gap handling.

Test Plan:
1. tx_len=64, buffer m[i]=i, tx_ready=1. Expect:
   - bytes 0x00..0x3F on consecutive cycles, tx_last on 0x3F;
   - first tx_valid 2 cycles after start;
   - irq_done 12 cycles after the last byte; frames_sent=1.
2. tx_len=10. Expect 60 bytes total: 0x00..0x09, then 50 bytes of 0x00, with tx_last on byte 60.
3. tx_len=64, tx_ready toggled 1,0,0,1 repeatedly. Expect no byte lost or duplicated, tx_data stable while stalled, and 64 bytes in order.
4. tx_len=0, then tx_len=1537. Expect an err_len pulse each time, busy stays 0, tx_valid never asserted, frames_sent unchanged.
5. start during STREAM and start with irq_done=1 are both ignored. irq_ack asserted in the same cycle irq_done sets: irq_done stays 1, then clears after a second ack.
6. rst pulsed at byte 20 of a 100-byte frame. Expect all outputs at reset values; a subsequent tx_len=60 frame completes normally with frames_sent=1.
